// File: rtl/irda_fir_rx_frame_fifo.sv
// IrDA FIR receive path: 32-bit data FIFO (first-word-fall-through) plus a
// per-frame status FIFO of {0, lost, rx_err_seen, crc_err, frame_len}.
//
// Optional feature macro: IRDA_RXFIFO_THRESH_IRQ_EN (registered level >= THRESH irq)
//
// Ports:
//   clk, wb_rst_i (async, active-high), flush (sync clear of everything)
//   push/push_dat          : word strobe from the FIR receiver
//   eof/crc_err/frame_len  : frame end strobe with its sampled results
//   rx_err                 : bad chip / break indication, folded into the frame record
//   pop/pop_dat/empty/full/level : host side of the data FIFO
//   st_pop/st_dat/st_valid : host side of the status FIFO
//   ovr_o                  : sticky drop indication (data word or status record)
//   thr_irq_o              : level >= THRESH
module irda_fir_rx_frame_fifo #(
    parameter int DW_LOG2 = 4,
    parameter int SW_LOG2 = 2,
    parameter int THRESH  = 8
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               flush,
    input  logic               push,
    input  logic [31:0]        push_dat,
    input  logic               eof,
    input  logic               crc_err,
    input  logic               rx_err,
    input  logic [15:0]        frame_len,
    input  logic               pop,
    output logic [31:0]        pop_dat,
    output logic               empty,
    output logic               full,
    output logic [DW_LOG2:0]   level,
    input  logic               st_pop,
    output logic [19:0]        st_dat,
    output logic               st_valid,
    output logic               ovr_o,
    output logic               thr_irq_o
);

    localparam int DEPTH  = 1 << DW_LOG2;
    localparam int SDEPTH = 1 << SW_LOG2;
    localparam logic [DW_LOG2:0] DEPTH_L  = DEPTH[DW_LOG2:0];
    localparam logic [SW_LOG2:0] SDEPTH_L = SDEPTH[SW_LOG2:0];

    logic [31:0]        mem  [DEPTH];
    logic [18:0]        smem [SDEPTH];

    logic [DW_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DW_LOG2:0]   level_next;
    logic [SW_LOG2-1:0] st_wr_ptr, st_rd_ptr;
    logic [SW_LOG2:0]   st_cnt, st_cnt_next;

    logic lost, rx_seen;
    logic do_pop, do_push, drop;
    logic st_do_pop, st_do_push, st_drop;
    logic [18:0] st_rec;

    // A full FIFO still takes a word when the same edge frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    assign st_do_pop  = st_pop && st_valid;
    assign st_do_push = eof && ((st_cnt != SDEPTH_L) || st_do_pop);
    assign st_drop    = eof && !st_do_push;

    // A word dropped on the eof edge still belongs to the ending frame.
    assign st_rec = {lost | drop, rx_seen | rx_err, crc_err, frame_len};

    assign pop_dat = mem[rd_ptr];
    assign st_dat  = {1'b0, smem[st_rd_ptr]};

    always_comb begin
        level_next = level;
        if (do_push && !do_pop)
            level_next = level + 1'b1;
        else if (do_pop && !do_push)
            level_next = level - 1'b1;
    end

    always_comb begin
        st_cnt_next = st_cnt;
        if (st_do_push && !st_do_pop)
            st_cnt_next = st_cnt + 1'b1;
        else if (st_do_pop && !st_do_push)
            st_cnt_next = st_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_dat;
        if (st_do_push && !flush)
            smem[st_wr_ptr] <= st_rec;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            st_wr_ptr <= '0;
            st_rd_ptr <= '0;
            st_cnt    <= '0;
            st_valid  <= 1'b0;
            lost      <= 1'b0;
            rx_seen   <= 1'b0;
            ovr_o     <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            st_wr_ptr <= '0;
            st_rd_ptr <= '0;
            st_cnt    <= '0;
            st_valid  <= 1'b0;
            lost      <= 1'b0;
            rx_seen   <= 1'b0;
            ovr_o     <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == DEPTH_L);

            if (st_do_push)
                st_wr_ptr <= st_wr_ptr + 1'b1;
            if (st_do_pop)
                st_rd_ptr <= st_rd_ptr + 1'b1;
            st_cnt   <= st_cnt_next;
            st_valid <= (st_cnt_next != '0);

            // Frame flags restart at every eof, whether or not the record fit.
            if (eof) begin
                lost    <= 1'b0;
                rx_seen <= 1'b0;
            end else begin
                lost    <= lost | drop;
                rx_seen <= rx_seen | rx_err;
            end

            ovr_o <= ovr_o | drop | st_drop;
        end
    end

`ifdef IRDA_RXFIFO_THRESH_IRQ_EN
    localparam logic [DW_LOG2:0] THRESH_L = THRESH[DW_LOG2:0];

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)
            thr_irq_o <= 1'b0;
        else if (flush)
            thr_irq_o <= 1'b0;
        else
            thr_irq_o <= (level_next >= THRESH_L);
    end
`else
    assign thr_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_irda_fir_rx_frame_fifo.sv
// Self-checking bench for irda_fir_rx_frame_fifo: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_irda_fir_rx_frame_fifo;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        flush = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_dat = '0;
    logic        eof = 1'b0;
    logic        crc_err = 1'b0;
    logic        rx_err = 1'b0;
    logic [15:0] frame_len = '0;
    logic        pop = 1'b0;
    logic [31:0] pop_dat;
    logic        empty, full;
    logic [4:0]  level;
    logic        st_pop = 1'b0;
    logic [19:0] st_dat;
    logic        st_valid, ovr_o, thr_irq_o;

    int checks = 0;
    int failures = 0;

    irda_fir_rx_frame_fifo #(.DW_LOG2(4), .SW_LOG2(2), .THRESH(8)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .flush(flush),
        .push(push), .push_dat(push_dat), .eof(eof),
        .crc_err(crc_err), .rx_err(rx_err), .frame_len(frame_len),
        .pop(pop), .pop_dat(pop_dat), .empty(empty), .full(full),
        .level(level), .st_pop(st_pop), .st_dat(st_dat),
        .st_valid(st_valid), .ovr_o(ovr_o), .thr_irq_o(thr_irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues and sticky bits.
    logic [31:0] dq[$];
    logic [19:0] sq[$];
    bit m_lost, m_rxs, m_ovr, m_thr;

`ifdef IRDA_RXFIFO_THRESH_IRQ_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    always @(posedge clk or posedge wb_rst_i) begin
        bit pok, wok, wdrop, spok, swok;
        if (wb_rst_i || flush) begin
            dq.delete();
            sq.delete();
            m_lost = 0; m_rxs = 0; m_ovr = 0; m_thr = 0;
        end else begin
            pok   = pop && dq.size() > 0;
            wok   = push && (dq.size() < 16 || pok);
            wdrop = push && !wok;
            spok  = st_pop && sq.size() > 0;
            swok  = eof && (sq.size() < 4 || spok);
            if (spok) void'(sq.pop_front());
            if (swok)
                sq.push_back({1'b0, m_lost | wdrop, m_rxs | rx_err,
                              crc_err, frame_len});
            if (pok) void'(dq.pop_front());
            if (wok) dq.push_back(push_dat);
            if (eof) begin
                m_lost = 0; m_rxs = 0;
            end else begin
                m_lost = m_lost | wdrop;
                m_rxs  = m_rxs | rx_err;
            end
            if (wdrop || (eof && !swok)) m_ovr = 1;
            m_thr = THR_EN && dq.size() >= 8;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!wb_rst_i) begin
            check("m_empty", 32'(empty), 32'(dq.size() == 0));
            check("m_full", 32'(full), 32'(dq.size() == 16));
            check("m_level", 32'(level), dq.size());
            if (dq.size() > 0) check("m_pop_dat", pop_dat, dq[0]);
            check("m_st_valid", 32'(st_valid), 32'(sq.size() > 0));
            if (sq.size() > 0) check("m_st_dat", 32'(st_dat), 32'(sq[0]));
            check("m_ovr", 32'(ovr_o), 32'(m_ovr));
            check("m_thr", 32'(thr_irq_o), 32'(m_thr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        push = 0; pop = 0; eof = 0; st_pop = 0; rx_err = 0; flush = 0;
        crc_err = 0;
    endtask

    task automatic do_push(input logic [31:0] d);
        push = 1; push_dat = d; step();
    endtask

    task automatic do_pop();
        pop = 1; step();
    endtask

    task automatic do_eof(input logic [15:0] len, input logic crc);
        eof = 1; frame_len = len; crc_err = crc; step();
    endtask

    task automatic do_flush();
        flush = 1; step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 wb_rst_i = 0;
        step();
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        check("rst_st_valid", 32'(st_valid), 0);
        check("rst_ovr", 32'(ovr_o), 0);
        check("rst_thr", 32'(thr_irq_o), 0);

        // Three-word frame
        do_push(32'h11111111);
        check("t1_vis", pop_dat, 32'h11111111);
        check("t1_nempty", 32'(empty), 0);
        do_push(32'h22222222);
        do_push(32'h33333333);
        do_eof(16'h0060, 1'b0);
        check("t1_st", 32'(st_dat), 32'h00060);
        check("t1_w0", pop_dat, 32'h11111111);
        do_pop();
        check("t1_w1", pop_dat, 32'h22222222);
        do_pop();
        check("t1_w2", pop_dat, 32'h33333333);
        do_pop();
        check("t1_empty", 32'(empty), 1);
        st_pop = 1; step();
        check("t1_st_gone", 32'(st_valid), 0);

        // Overflow: 17 pushes
        for (int i = 0; i < 17; i++) do_push(32'h1000 + i);
        check("t2_level", 32'(level), 16);
        check("t2_full", 32'(full), 1);
        check("t2_ovr", 32'(ovr_o), 1);
        do_eof(16'h0011, 1'b0);
        check("t2_lost", 32'(st_dat[18]), 1);

        // Push+pop on full
        push = 1; push_dat = 32'hAAAAAAAA; pop = 1; step();
        check("t3_level", 32'(level), 16);
        for (int i = 1; i < 16; i++) begin
            check("t3_order", pop_dat, 32'h1000 + i);
            do_pop();
        end
        check("t3_last", pop_dat, 32'hAAAAAAAA);
        do_pop();
        check("t3_empty", 32'(empty), 1);
        st_pop = 1; step();

        do_flush();
        check("fl_ovr", 32'(ovr_o), 0);

        // rx_err mid-frame, crc error
        do_push(32'h5);
        rx_err = 1; step();
        do_push(32'h6);
        do_eof(16'h0002, 1'b1);
        check("t4_err", 32'(st_dat[17:16]), 2'b11);
        st_pop = 1; step();
        do_eof(16'h0003, 1'b0);
        check("t4_clear", 32'(st_dat), 32'h00003);
        st_pop = 1; step();
        do_pop(); do_pop();

        // Status overflow
        for (int i = 0; i < 5; i++) do_eof(16'(i + 1), 1'b0);
        check("t5_ovr", 32'(ovr_o), 1);
        check("t5_head", 32'(st_dat), 32'h00001);
        eof = 1; frame_len = 16'h0077; st_pop = 1; step();
        check("t5_head2", 32'(st_dat), 32'h00002);
        do_flush();
        check("t5_st_valid", 32'(st_valid), 0);
        check("t5_empty", 32'(empty), 1);
        check("t5_ovr0", 32'(ovr_o), 0);

        // Empty edge cases
        do_pop();
        check("t6_pop_empty", 32'(level), 0);
        push = 1; push_dat = 32'hBEEF; pop = 1; step();
        check("t6_pp_empty", 32'(level), 1);
        check("t6_pp_dat", pop_dat, 32'hBEEF);
        do_pop();

        // Threshold irq
        for (int i = 0; i < 7; i++) do_push(32'(i));
        check("t7_thr7", 32'(thr_irq_o), 0);
        do_push(32'h7);
        check("t7_thr8", 32'(thr_irq_o), 32'(THR_EN));
        do_pop();
        check("t7_thr_fall", 32'(thr_irq_o), 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
